fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the single-cycle MIPS `machine`, directly upstream of decode/register-file/datapath. Owns the program counter and drives the instruction-memory address. Selects the next PC from sequential, branch, jump and jump-register sources. Detects end-of-program (all-zero instruction, misaligned `jr`, cycle budget) and freezes the machine so the bench can dump registers and memory deterministically.

## Interface
- `RESET_PC`, 32'h0040_0000: PC loaded on reset; bits [1:0] must be 0.
- `CYCLE_LIMIT`, 64: RUN cycles (stalls included) before a forced halt; range 1..65535.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC this cycle; no retire.
- `inst`  in  32  instruction read combinationally from imem at `pc`.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_offset`  in  16  raw immediate, word offset.
- `jump`  in  1  j/jal.
- `jump_index`  in  26  instr_index field.
- `jr`  in  1  jr/jalr.
- `jr_target`  in  32  register value for jr.
- `pc`  out  32  current PC to imem; bits [1:0] always 0.
- `pc_plus4`  out  32  `pc + 4`, for jal link and datapath.
- `halted`  out  1  machine stopped.
- `halt_cause`  out  2  00 none, 01 zero instruction, 10 cycle limit, 11 misaligned jr.
- `cycle_count`  out  16  RUN cycles elapsed.
- `retired_count`  out  16  instructions retired.

## Operation
- States: RUN, HALT. HALT left only by `reset`.
- PC held as 30-bit register (word address); `pc = {pc_q, 2'b00}`.
- Next-PC priority: `jr` > `jump` > `branch_taken` > sequential.
  - sequential: `pc + 4`.
  - branch: `pc + 4 + (sext(branch_offset) << 2)`, mod 2^32.
  - jump: `{pc_plus4[31:28], jump_index, 2'b00}`.
  - jr: `jr_target`, only if `jr_target[1:0] == 0`.
- Per RUN cycle, evaluated in order:
  1. `inst == 0` (including `stall` high): -> HALT, cause 01; PC, retired_count unchanged.
  2. Else if `stall`: PC and retired_count held.
  3. Else if `jr` and `jr_target[1:0] != 0`: -> HALT, cause 11; PC unchanged, no retire.
  4. Else: PC <= next-PC; retired_count += 1.
  5. Independently of 1-4, cycle_count += 1. If it was `CYCLE_LIMIT-1` and cases 1/3 did not fire: -> HALT, cause 10. The step-4 retire still happens.
- HALT: PC, counters and halt_cause frozen; all inputs ignored.
- Counters are 16-bit and saturate at 0xFFFF; they never wrap.
- An `inst` containing X/Z is not treated as zero; no halt.

## Timing
- Reset (async, immediate): `pc = RESET_PC`, `pc_plus4 = RESET_PC+4`, `halted = 0`, `halt_cause = 00`, both counters 0, state RUN.
- Reset asserted mid-run or during HALT: same values immediately, regardless of clock.
- `pc` changes only on rising `clk` edges, one cycle after the selecting inputs are sampled.
- `halted` and `halt_cause` rise on the same edge that detects the condition. Zero-latency visibility of the trigger is not provided.
- `pc_plus4` is combinational from `pc`.
- After the halting edge, `pc` still addresses the halting instruction (cases 1, 3) or its successor (case 5).

## Structure
- Shared package `fetch_pkg`:
  - state enum `{RUN, HALT}`;
  - halt-cause constants `HALT_NONE`, `HALT_ZERO`, `HALT_LIMIT`, `HALT_JR_ALIGN`;
  - `RESET_PC` default value.
- One sub-module, `fetch_next_pc`: combinational next-PC mux plus misalignment flag.
- The parent holds the PC register, FSM and counters.

## Test plan
- Reset, `inst = 0x20020001` for 3 cycles -> `pc` 0x00400000, 0x00400004, 0x00400008, 0x0040000C; retired 3, cycle 3.
- At `pc = 0x00400008`, branch taken, offset 0xFFFE -> next `pc = 0x00400004`. With `jump` also high and index 0x0100010 -> `pc = 0x00400040` (jump wins).
- `stall` high 2 cycles at 0x00400004 -> `pc` held; cycle +2, retired +0. `inst = 0` while stalled -> `halted = 1`, cause 01, `pc` stays 0x00400004.
- `jr`, `jr_target = 0x00400022` -> `halted`, cause 11, `pc` unchanged. With `jr_target = 0x00400020` -> `pc = 0x00400020`.
- `CYCLE_LIMIT = 4`, nonzero `inst` -> halt on 4th edge, cause 10, `pc = 0x00400010`, retired 4. Further clocks change nothing.
- Assert `reset` between clock edges while halted -> outputs return to reset values before the next edge; run resumes after deassert.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic [1:0] HALT_NONE     = 2'b00;
   localparam logic [1:0] HALT_ZERO     = 2'b01;
   localparam logic [1:0] HALT_LIMIT    = 2'b10;
   localparam logic [1:0] HALT_JR_ALIGN = 2'b11;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: jr > jump > taken branch > sequential, on word addresses.
// Latency: purely combinational.
// Backpressure: none; the parent decides whether the result is loaded.
// Ports: pc_word (current PC >> 2), branch/jump/jr controls in,
//        next_word (selected PC >> 2) and jr_misaligned out.
module fetch_next_pc (
   input  logic [29:0] pc_word,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [29:0] next_word,
   output logic        jr_misaligned
);

   logic [29:0] seq_word;
   logic [29:0] branch_word;

   always_comb begin
      seq_word    = pc_word + 30'd1;
      // Offset is already in words, so working on word addresses drops the << 2.
      branch_word = seq_word + {{14{branch_offset[15]}}, branch_offset};
      next_word   = seq_word;
      if (jr) begin
         next_word = jr_target[31:2];
      end else if (jump) begin
         // seq_word[29:26] is bits [31:28] of pc+4.
         next_word = {seq_word[29:26], jump_index};
      end else if (branch_taken) begin
         next_word = branch_word;
      end
      jr_misaligned = jr && (jr_target[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT control, cycle and retire counters.
// Latency: PC updates one clock after its selecting inputs; halt flags on the detecting edge.
// Backpressure: stall holds PC and retire count; HALT freezes everything until reset.
// Ports: clk/reset, stall, inst, branch/jump/jr controls in;
//        pc, pc_plus4, halted, halt_cause, cycle_count, retired_count out.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned CYCLE_LIMIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] inst,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic [1:0]  halt_cause,
   output logic [15:0] cycle_count,
   output logic [15:0] retired_count
);

   localparam logic [15:0] LIMIT_LAST = 16'(CYCLE_LIMIT - 1);

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [1:0]  cause_q, cause_d;
   logic [15:0] cyc_q, cyc_d;
   logic [15:0] ret_q, ret_d;

   logic [29:0] next_word;
   logic        jr_misaligned;

   fetch_next_pc u_next_pc (
      .pc_word       (pc_q),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_target     (jr_target),
      .next_word     (next_word),
      .jr_misaligned (jr_misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      cyc_d   = cyc_q;
      ret_d   = ret_q;
      if (state_q == RUN) begin
         cyc_d = sat_inc(cyc_q);
         // An X/Z instruction makes this compare unknown, which falls through
         // to normal execution rather than halting.
         if (inst == 32'd0) begin
            state_d = HALT;
            cause_d = HALT_ZERO;
         end else if (!stall) begin
            if (jr_misaligned) begin
               state_d = HALT;
               cause_d = HALT_JR_ALIGN;
            end else begin
               pc_d  = next_word;
               ret_d = sat_inc(ret_q);
            end
         end
         // Budget halt only when no instruction-driven halt fired this cycle;
         // the retire above still lands.
         if (state_d == RUN && cyc_q == LIMIT_LAST) begin
            state_d = HALT;
            cause_d = HALT_LIMIT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC[31:2];
         cause_q <= HALT_NONE;
         cyc_q   <= 16'd0;
         ret_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         cyc_q   <= cyc_d;
         ret_q   <= ret_d;
      end
   end

   assign pc            = {pc_q, 2'b00};
   assign pc_plus4      = pc + 32'd4;
   assign halted        = (state_q == HALT);
   assign halt_cause    = cause_q;
   assign cycle_count   = cyc_q;
   assign retired_count = ret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a high-level model predicts each edge's outcome,
// a monitor compares after every rising edge; async reset checked directly.
module tb_fetch_unit;

   localparam logic [31:0] RPC   = 32'h0040_0000;
   localparam int          LIMIT = 24;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [31:0] inst = 32'h2002_0001;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = 16'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'd0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = 32'd0;
   logic [31:0] pc, pc_plus4;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [15:0] cycle_count, retired_count;

   fetch_unit #(.RESET_PC(RPC), .CYCLE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .stall(stall), .inst(inst),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
      .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .halt_cause(halt_cause),
      .cycle_count(cycle_count), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic        halted;
      logic [1:0]  cause;
      int          cyc;
      int          ret;
   } exp_t;

   logic [31:0] m_pc;
   logic        m_halt;
   logic [1:0]  m_cause;
   int          m_cyc, m_ret;
   exp_t        sb_q[$];

   task automatic model_reset();
      m_pc = RPC; m_halt = 1'b0; m_cause = 2'd0; m_cyc = 0; m_ret = 0;
   endtask

   task automatic model_step();
      logic [31:0] p4, target;
      int          sx;
      bit          instr_halt;
      exp_t        e;
      if (!m_halt) begin
         p4 = m_pc + 32'd4;
         sx = int'($signed(branch_offset));
         if (jr)                target = jr_target;
         else if (jump)         target = {p4[31:28], jump_index, 2'b00};
         else if (branch_taken) target = p4 + 32'(sx * 4);
         else                   target = p4;
         instr_halt = 1'b0;
         if (inst == 32'd0) begin
            instr_halt = 1'b1; m_cause = 2'b01;
         end else if (stall) begin
            // held
         end else if (jr && jr_target[1:0] != 2'b00) begin
            instr_halt = 1'b1; m_cause = 2'b11;
         end else begin
            m_pc = target;
            if (m_ret < 65535) m_ret++;
         end
         if (!instr_halt && m_cyc == LIMIT - 1) m_cause = 2'b10;
         m_halt = instr_halt || (m_cyc == LIMIT - 1);
         if (m_cyc < 65535) m_cyc++;
      end
      e.pc = m_pc; e.halted = m_halt; e.cause = m_cause; e.cyc = m_cyc; e.ret = m_ret;
      sb_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("pc", pc, mon_e.pc);
         check("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
         check("halted", {31'd0, halted}, {31'd0, mon_e.halted});
         check("halt_cause", {30'd0, halt_cause}, {30'd0, mon_e.cause});
         check("cycle_count", {16'd0, cycle_count}, 32'(mon_e.cyc));
         check("retired_count", {16'd0, retired_count}, 32'(mon_e.ret));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_inputs();
      stall = 1'b0; inst = 32'h2002_0001; branch_taken = 1'b0; branch_offset = 16'd0;
      jump = 1'b0; jump_index = 26'd0; jr = 1'b0; jr_target = 32'd0;
   endtask

   // Called with inputs already driven, in the low phase of the clock.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges, with immediate-visibility checks.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_pc", pc, RPC);
      check("rst_pc_plus4", pc_plus4, RPC + 32'd4);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_cause", {30'd0, halt_cause}, 32'd0);
      check("rst_cycle", {16'd0, cycle_count}, 32'd0);
      check("rst_retired", {16'd0, retired_count}, 32'd0);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic random_inputs();
      logic [31:0] r;
      r = $urandom;
      inst          = ($urandom_range(0, 15) == 0) ? 32'd0 : (r | 32'd1);
      stall         = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      r = $urandom;
      branch_offset = r[15:0];
      jump          = ($urandom_range(0, 4) == 0);
      jump_index    = r[31:6];
      jr            = ($urandom_range(0, 5) == 0);
      r = $urandom;
      jr_target     = {r[31:2], ($urandom_range(0, 3) == 0) ? 2'(r[1:0] | 2'b01) : 2'b00};
   endtask

   initial begin
      model_reset();
      idle_inputs();
      @(negedge clk);
      do_reset();

      // Sequential fetch, branch back, jump beats branch.
      tick(); tick();
      branch_taken = 1'b1; branch_offset = 16'hFFFE; tick();     // 0x08 -> 0x04
      idle_inputs(); tick();                                      // -> 0x08
      branch_taken = 1'b1; branch_offset = 16'hFFFE;
      jump = 1'b1; jump_index = 26'h0100010; tick();              // -> 0x40
      idle_inputs(); tick();

      // Stall, then zero instruction while stalled.
      do_reset();
      tick();                                                     // -> 0x04
      stall = 1'b1; tick(); tick();
      inst = 32'd0; tick();                                       // halt, cause 01
      random_inputs(); tick(); random_inputs(); tick();           // frozen

      // Misaligned jr halts; aligned jr redirects.
      do_reset();
      idle_inputs(); jr = 1'b1; jr_target = 32'h0040_0022; tick();
      idle_inputs(); tick();
      do_reset();
      jr = 1'b1; jr_target = 32'h0040_0020; tick();
      idle_inputs();

      // Run into the cycle budget, then stay frozen.
      for (int i = 0; i < LIMIT + 3; i++) tick();

      // Async reset while halted, then resume.
      do_reset();
      tick(); tick();

      // Randomized runs, many of which end in one of the halt causes.
      for (int run = 0; run < 25; run++) begin
         do_reset();
         for (int c = 0; c < 30; c++) begin
            random_inputs();
            tick();
         end
      end

      @(posedge clk); #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
